// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg: shared constants and types for the 14-bit-instruction CPU core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int PC_W        = 11;
    localparam int STACK_DEPTH = 16;

    typedef logic [PC_W-1:0] pc_t;

    // Decoded {push,pop} request
    typedef enum logic [1:0] {
        STK_IDLE = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2,
        STK_REPL = 2'd3
    } stk_op_e;

endpackage

`default_nettype wire

// File: rtl/lifo_ptr.sv
//------------------------------------------------------------------------------
// lifo_ptr: write pointer, occupancy counter and sticky flags of the return stack.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lifo_ptr
    import cpu_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_flags,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_idx,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    stk_op_e       op;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_idx = wp_q - PW'(1);

    always_comb begin
        unique case ({push, pop})
            2'b10:   op = STK_PUSH;
            2'b01:   op = STK_POP;
            2'b11:   op = STK_REPL;
            default: op = STK_IDLE;
        endcase
    end

    always_comb begin
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        ovf_d  = clr_flags ? 1'b0 : ovf_q;
        unf_d  = clr_flags ? 1'b0 : unf_q;
        wr_en  = 1'b0;
        wr_idx = wp_q;
        unique case (op)
            STK_PUSH: begin
                // When full, wp already points at the oldest entry, so it is overwritten
                wr_en = 1'b1;
                wp_d  = wp_q + PW'(1);
                if (full) ovf_d = 1'b1;
                else      cnt_d = cnt_q + CW'(1);
            end
            STK_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    wp_d  = wp_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STK_REPL: begin
                wr_en = 1'b1;
                if (empty) begin
                    wp_d  = wp_q + PW'(1);
                    cnt_d = CW'(1);
                    unf_d = 1'b1;
                end else begin
                    wr_idx = rd_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign depth   = cnt_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

`default_nettype wire

// File: rtl/call_return_stack.sv
//------------------------------------------------------------------------------
// call_return_stack: circular return-address LIFO feeding the PC-next mux.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module call_return_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = PC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          stack_in,
    output logic [AW-1:0]          stack_out,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   empty,
    output logic                   full,
    output logic                   stk_ovf,
    output logic                   stk_unf,
    input  logic                   clr_flags
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    lifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clr_flags (clr_flags),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    // Entry array is deliberately unreset; the empty gate below hides stale data
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= stack_in;
    end

    assign stack_out = empty ? '0 : mem_q[rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_call_return_stack.sv
//------------------------------------------------------------------------------
// tb_call_return_stack: scoreboard bench for the return-address stack.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_return_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_flags = 1'b0;
    logic [AW-1:0] stack_in = '0;
    logic [AW-1:0] stack_out;
    logic [4:0]    depth;
    logic          empty, full, stk_ovf, stk_unf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int so; int dp; int em; int fu; int ov; int un;
    } exp_t;

    exp_t sb[$];

    // Reference model
    int m[DEPTH];
    int mwp = 0, mcnt = 0, movf = 0, munf = 0;

    call_return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .stack_in  (stack_in),
        .stack_out (stack_out),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_top();
        return (mcnt == 0) ? 0 : m[(mwp + DEPTH - 1) % DEPTH];
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        e.so = model_top();
        e.dp = mcnt;
        e.em = (mcnt == 0) ? 1 : 0;
        e.fu = (mcnt == DEPTH) ? 1 : 0;
        e.ov = movf;
        e.un = munf;
        return e;
    endfunction

    function automatic void model_reset();
        mwp = 0; mcnt = 0; movf = 0; munf = 0;
    endfunction

    function automatic void model_step(input int p, input int q, input int din, input int clr);
        if (clr != 0) begin movf = 0; munf = 0; end
        if (p != 0 && q == 0) begin
            m[mwp] = din;
            mwp = (mwp + 1) % DEPTH;
            if (mcnt == DEPTH) movf = 1;
            else mcnt++;
        end else if (p == 0 && q != 0) begin
            if (mcnt == 0) munf = 1;
            else begin mwp = (mwp + DEPTH - 1) % DEPTH; mcnt--; end
        end else if (p != 0 && q != 0) begin
            if (mcnt == 0) begin
                m[mwp] = din; mwp = (mwp + 1) % DEPTH; mcnt = 1; munf = 1;
            end else begin
                m[(mwp + DEPTH - 1) % DEPTH] = din;
            end
        end
    endfunction

    task automatic compare_state(input string tag, input exp_t e);
        chk({tag, ".stack_out"}, int'(stack_out), e.so);
        chk({tag, ".depth"},     int'(depth),     e.dp);
        chk({tag, ".empty"},     int'(empty),     e.em);
        chk({tag, ".full"},      int'(full),      e.fu);
        chk({tag, ".ovf"},       int'(stk_ovf),   e.ov);
        chk({tag, ".unf"},       int'(stk_unf),   e.un);
    endtask

    // One cycle of stimulus; a pop also checks the same-cycle read of the top
    task automatic step(input string tag, input bit p, input bit q, input int din, input bit clr);
        exp_t e;
        @(negedge clk);
        push = p; pop = q; stack_in = AW'(din); clr_flags = clr;
        #1;
        if (q) chk({tag, ".ret"}, int'(stack_out), model_top());
        model_step(int'(p), int'(q), din, int'(clr));
        sb.push_back(model_snapshot());
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            compare_state(tag, e);
        end
    endtask

    initial begin
        // Reset held low: outputs defined without any clock
        #2;
        model_reset();
        compare_state("reset", model_snapshot());
        @(negedge clk);
        rst = 1'b1;
        step("idle", 0, 0, 0, 0);

        step("push123", 1, 0, 'h123, 0);
        step("push456", 1, 0, 'h456, 0);
        step("push7ff", 1, 0, 'h7FF, 0);
        chk("three.depth", int'(depth), 3);
        chk("three.top", int'(stack_out), 'h7FF);
        for (int i = 0; i < 3; i++) step("pop3", 0, 1, 0, 0);
        chk("drained.empty", int'(empty), 1);

        for (int i = 0; i <= DEPTH; i++) step("fill", 1, 0, i, 0);
        chk("fill.top", int'(stack_out), 16);
        chk("fill.ovf", int'(stk_ovf), 1);
        for (int i = 0; i < DEPTH; i++) step("unwind", 0, 1, 0, 0);
        chk("unwind.empty", int'(empty), 1);

        step("clr_ovf", 0, 0, 0, 1);
        step("pop_empty", 0, 1, 0, 0);
        chk("pop_empty.unf", int'(stk_unf), 1);
        step("clr", 0, 0, 0, 1);
        step("set_wins", 0, 1, 0, 1);
        step("clr2", 0, 0, 0, 1);

        step("push005", 1, 0, 'h005, 0);
        step("push010", 1, 0, 'h010, 0);
        step("repl020", 1, 1, 'h020, 0);
        chk("repl.top", int'(stack_out), 'h020);
        step("pop_r1", 0, 1, 0, 0);
        step("pop_r2", 0, 1, 0, 0);
        step("repl_empty", 1, 1, 'h3AB, 0);
        step("clr3", 0, 0, 0, 1);

        for (int i = 0; i < 4; i++) step("rand", 1, 0, int'($urandom_range(0, 2047)), 0);
        chk("pre_rst.depth", int'(depth), 5);

        // Asynchronous reset mid-cycle, checked before the next rising edge
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        compare_state("async_rst", model_snapshot());
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/call_return_stack.md
# call_return_stack

Hardware return-address stack for the 14-bit-instruction CPU core. It holds 11-bit program-counter values. A CALL pushes the return address, and a RETURN pops it back into the PC-next mux (select 2). The stack is a circular LIFO with depth tracking and sticky overflow/underflow status, mirroring the PIC16 wrap-around behaviour. It sits directly beside the PC register: it consumes `PC_q` and produces the value the PC loads on RETURN.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `AW`, 11: address width, equal to the PC width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `push`  in  1  write `stack_in` as the new top-of-stack this cycle.
- `pop`  in  1  remove the top-of-stack this cycle.
- `stack_in`  in  AW  return address to push; driven by `PC_q`.
- `stack_out`  out  AW  current top-of-stack, combinational read.
- `depth`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  high when `depth`==0.
- `full`  out  1  high when `depth`==DEPTH.
- `stk_ovf`  out  1  sticky; set by a push while full.
- `stk_unf`  out  1  sticky; set by a pop while empty.
- `clr_flags`  in  1  synchronous clear of `stk_ovf` and `stk_unf`.

## Operation
- Internal state:
  - entry array `mem[DEPTH]` of AW bits;
  - write pointer `wp`, $clog2(DEPTH) bits, modulo DEPTH;
  - counter `cnt`, 0..DEPTH.
- Top index is `wp-1` modulo DEPTH. `stack_out` = `mem[wp-1]` when `cnt`>0, otherwise 0.
- Per-cycle operation is selected by {push,pop}:
- 00, idle: no state change.
- 10, push:
  - `mem[wp]` <= `stack_in`; `wp` <= `wp+1` (wraps).
  - If not full, `cnt` <= `cnt+1`.
  - If full, `cnt` stays at DEPTH, the oldest entry is overwritten, and `stk_ovf` <= 1.
- 01, pop:
  - If not empty: `wp` <= `wp-1`, `cnt` <= `cnt-1`.
  - If empty: `wp` and `cnt` are unchanged and `stk_unf` <= 1.
- 11, replace:
  - If not empty: `mem[wp-1]` <= `stack_in`; `wp` and `cnt` are unchanged; no flag.
  - If empty: behaves as a push (`cnt` 0->1) and `stk_unf` <= 1.
- Flags are sticky until `clr_flags` or reset.
  - If `clr_flags` coincides with a flag-setting event, the set wins.
- Memory contents are not reset. Gating of `stack_out` by `empty` keeps all outputs defined after reset.

## Timing
- Reset, with `rst` low asynchronously:
  - `wp`=0, `cnt`=0;
  - `stack_out`=0, `depth`=0, `empty`=1, `full`=0, `stk_ovf`=0, `stk_unf`=0.
- The first clock edge after `rst` deasserts is a normal operating edge.
- Reset asserted mid-sequence discards all entries immediately; no partial push survives.
- Read latency is 0 cycles: `stack_out` reflects the top in the same cycle. The core samples it in the RETURN execute state, coincident with `pop`.
- Write latency is 1 cycle: a value pushed at edge N is visible on `stack_out` after edge N.
- After a pop at edge N, `stack_out` shows the next-lower entry after edge N.
- Strobes are single-cycle and level-sampled. The core asserts `push` or `pop` for exactly one cycle per instruction; no handshake or back-pressure.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W`=11 and `STACK_DEPTH`=16 constants;
  - `typedef logic [PC_W-1:0] pc_t`;
  - `typedef enum {STK_IDLE, STK_PUSH, STK_POP, STK_REPL} stk_op_e`, the decoded {push,pop} operation.
- One sub-module, `lifo_ptr`: owns `wp`, `cnt`, `full`/`empty` and the flag logic.
- The top level holds the entry array, the write port and the read mux.

## Test plan
- Reset then idle: `depth`=0, `empty`=1, `stack_out`=0, both flags 0.
- Push 0x123, 0x456, 0x7FF:
  - `depth`=3 and `stack_out`=0x7FF;
  - three pops yield 0x456, 0x123, then `empty`=1 with `stack_out`=0.
- Push 17 values 0..16 with DEPTH=16:
  - `full`=1, `stk_ovf`=1, `stack_out`=16;
  - 16 pops return 16 down to 1; the value 0 is lost.
- Pop while empty: `stk_unf`=1 and `depth` stays 0. Then `clr_flags`: both flags return to 0.
- Push and pop together:
  - with `depth`=2 and top 0x010, `stack_in`=0x020: `depth` stays 2 and `stack_out`=0x020;
  - with `depth`=0: `depth` goes to 1 and `stk_unf`=1.
- Reset mid-stack: assert `rst` low asynchronously with `depth`=5. Outputs go to reset values before the next clock edge.
